mult_div_unit: RTL and testbench

Iterative multiply/divide unit with architectural HI/LO registers for the MIPS datapath. It sits directly downstream of the register file and takes its two read ports (rs, rt) as operands. It executes MULT, MULTU, DIV and DIVU over a fixed 33-cycle sequence, and supports direct HI/LO writes for MTHI/MTLO. Hi/Lo are read continuously by the MFHI/MFLO path.

---
 rtl/mult_div_unit.sv | 143 ++++++++++++++
 tb/tb_mult_div_unit.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mult_div_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit with architectural HI/LO registers.
// 33-cycle latency from the Start edge to Hi/Lo; Start and MTHI/MTLO are ignored while Busy.
module mult_div_unit #(
  parameter int WIDTH = 32
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic             Start,
  input  logic [1:0]       Op,
  input  logic [WIDTH-1:0] Operand_A,
  input  logic [WIDTH-1:0] Operand_B,
  input  logic             Write_Hi,
  input  logic             Write_Lo,
  input  logic [WIDTH-1:0] Write_Data,
  output logic             Busy,
  output logic             Done,
  output logic             Div_By_Zero,
  output logic [WIDTH-1:0] Hi,
  output logic [WIDTH-1:0] Lo
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, RUN, FINISH} state_t;

  state_t             state, state_nxt;
  logic [CW-1:0]      count;
  logic               is_div, sign_a, sign_b, div_zero;
  logic [WIDTH-1:0]   orig_a, oper;
  logic [2*WIDTH-1:0] acc;

  // Operand preparation at Start: Op[0]=0 selects the signed variants
  logic             a_neg, b_neg;
  logic [WIDTH-1:0] abs_a, abs_b;

  always_comb begin
    a_neg = ~Op[0] & Operand_A[WIDTH-1];
    b_neg = ~Op[0] & Operand_B[WIDTH-1];
    abs_a = a_neg ? -Operand_A : Operand_A;
    abs_b = b_neg ? -Operand_B : Operand_B;
  end

  // One iteration of each algorithm; acc holds {hi, lo} or {remainder, quotient}
  logic [WIDTH:0]     mul_sum, div_shift, div_diff;
  logic               div_ok;
  logic [2*WIDTH-1:0] acc_mul_nxt, acc_div_nxt;

  always_comb begin
    mul_sum     = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, oper} : '0);
    acc_mul_nxt = {mul_sum, acc[WIDTH-1:1]};
    div_shift   = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
    div_diff    = div_shift - {1'b0, oper};
    div_ok      = ~div_diff[WIDTH];
    acc_div_nxt = {(div_ok ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0]),
                   acc[WIDTH-2:0], div_ok};
  end

  // Sign correction and the divide-by-zero override applied in FINISH
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   res_hi, res_lo;

  always_comb begin
    prod_fix = (sign_a ^ sign_b) ? -acc : acc;
    res_hi   = prod_fix[2*WIDTH-1:WIDTH];
    res_lo   = prod_fix[WIDTH-1:0];
    if (is_div) begin
      if (div_zero) begin
        res_hi = orig_a;
        res_lo = '1;
      end else begin
        res_hi = sign_a ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
        res_lo = (sign_a ^ sign_b) ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
      end
    end
  end

  always_ff @(posedge Clock) begin
    if (Reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (Start) state_nxt = RUN;
      RUN:     if (count == CW'(WIDTH-1)) state_nxt = FINISH;
      FINISH:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      Hi          <= '0;
      Lo          <= '0;
      Busy        <= 1'b0;
      Done        <= 1'b0;
      Div_By_Zero <= 1'b0;
      count       <= '0;
      is_div      <= 1'b0;
      sign_a      <= 1'b0;
      sign_b      <= 1'b0;
      div_zero    <= 1'b0;
      orig_a      <= '0;
      oper        <= '0;
      acc         <= '0;
    end else begin
      Done        <= 1'b0;
      Div_By_Zero <= 1'b0;
      case (state)
        IDLE: begin
          if (Start) begin
            is_div   <= Op[1];
            sign_a   <= a_neg;
            sign_b   <= b_neg;
            div_zero <= Op[1] & (Operand_B == '0);
            orig_a   <= Operand_A;
            oper     <= Op[1] ? abs_b : abs_a;
            acc      <= {{WIDTH{1'b0}}, (Op[1] ? abs_a : abs_b)};
            count    <= '0;
            Busy     <= 1'b1;
          end else begin
            if (Write_Hi) Hi <= Write_Data;
            if (Write_Lo) Lo <= Write_Data;
          end
        end
        RUN: begin
          acc   <= is_div ? acc_div_nxt : acc_mul_nxt;
          count <= count + 1'b1;
        end
        FINISH: begin
          Hi          <= res_hi;
          Lo          <= res_lo;
          Done        <= 1'b1;
          Div_By_Zero <= is_div & div_zero;
          Busy        <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mult_div_unit.sv
// Randomized and directed bench for mult_div_unit against an arithmetic reference model.
module tb_mult_div_unit;
  localparam int W = 32;

  logic         Clock = 1'b0;
  logic         Reset, Start, Write_Hi, Write_Lo;
  logic [1:0]   Op;
  logic [W-1:0] Operand_A, Operand_B, Write_Data;
  logic         Busy, Done, Div_By_Zero;
  logic [W-1:0] Hi, Lo;

  int n_checks = 0;
  int n_fail   = 0;

  mult_div_unit #(.WIDTH(W)) dut (
    .Clock(Clock), .Reset(Reset), .Start(Start), .Op(Op),
    .Operand_A(Operand_A), .Operand_B(Operand_B),
    .Write_Hi(Write_Hi), .Write_Lo(Write_Lo), .Write_Data(Write_Data),
    .Busy(Busy), .Done(Done), .Div_By_Zero(Div_By_Zero), .Hi(Hi), .Lo(Lo)
  );

  always #5 Clock = ~Clock;

  // Returns {div_by_zero, hi, lo} from plain 64-bit arithmetic
  function automatic logic [64:0] model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    longint      sa, sb, q, r;
    logic [63:0] p;
    logic [31:0] uq, ur;
    logic        dz;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    dz = 1'b0;
    p  = '0;
    case (op)
      2'd0: p = sa * sb;
      2'd1: p = {32'h0, a} * {32'h0, b};
      default: begin
        if (b == 32'h0) begin
          dz = 1'b1;
          p  = {a, 32'hFFFF_FFFF};
        end else if (op == 2'd2) begin
          q = sa / sb;
          r = sa % sb;
          p = {r[31:0], q[31:0]};
        end else begin
          uq = a / b;
          ur = a % b;
          p  = {ur, uq};
        end
      end
    endcase
    return {dz, p};
  endfunction

  // Called at a falling edge; returns at the falling edge where Done is seen
  task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        input bit disturb,
                        output logic [31:0] hi, output logic [31:0] lo, output logic dz,
                        output int lat, output int busy_cyc, output bit early_change);
    logic [31:0] hi0, lo0;
    hi0 = Hi; lo0 = Lo;
    hi = 'x; lo = 'x; dz = 1'bx;
    lat = -1; busy_cyc = 0; early_change = 0;
    Start = 1'b1; Op = op; Operand_A = a; Operand_B = b;
    @(negedge Clock);
    Start = 1'b0; Op = 2'($urandom); Operand_A = $urandom; Operand_B = $urandom;
    for (int c = 0; c < 40; c++) begin
      if (c > 0) @(negedge Clock);
      if (Busy) busy_cyc++;
      if (Done) begin
        lat = c; hi = Hi; lo = Lo; dz = Div_By_Zero;
        break;
      end
      if (Hi !== hi0 || Lo !== lo0) early_change = 1;
      if (disturb && c == 5) begin
        Start = 1'b1; Write_Hi = 1'b1; Write_Lo = 1'b1; Write_Data = $urandom;
        Operand_A = $urandom; Operand_B = $urandom;
      end else begin
        Start = 1'b0; Write_Hi = 1'b0; Write_Lo = 1'b0;
      end
    end
    Start = 1'b0; Write_Hi = 1'b0; Write_Lo = 1'b0;
  endtask

  task automatic test_reset();
    Reset = 1'b1; Start = 1'b0; Write_Hi = 1'b0; Write_Lo = 1'b0;
    Op = 2'd0; Operand_A = '0; Operand_B = '0; Write_Data = '0;
    repeat (2) @(negedge Clock);
    Reset = 1'b0; Write_Hi = 1'b1; Write_Lo = 1'b1; Write_Data = 32'hA5A5_0F0F;
    @(negedge Clock);
    Write_Hi = 1'b0; Write_Lo = 1'b0;
    n_checks++;
    if (Hi !== 32'hA5A5_0F0F || Lo !== 32'hA5A5_0F0F) begin
      n_fail++; $display("FAIL mthi_mtlo_both: hi=%h lo=%h want a5a50f0f", Hi, Lo);
    end
    Reset = 1'b1;
    @(negedge Clock);
    Reset = 1'b0;
    @(negedge Clock);
    n_checks++;
    if ({Hi, Lo, Busy, Done, Div_By_Zero} !== '0) begin
      n_fail++;
      $display("FAIL reset_state: hi=%h lo=%h busy=%b done=%b dz=%b want all 0", Hi, Lo, Busy, Done, Div_By_Zero);
    end
  endtask

  task automatic test_mult_unsigned();
    logic [31:0] hi, lo; logic dz; int lat, bc; bit ec;
    run_op(2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, hi, lo, dz, lat, bc, ec);
    n_checks++;
    if ({hi, lo, dz} !== {32'hFFFF_FFFE, 32'h0000_0001, 1'b0}) begin
      n_fail++; $display("FAIL multu_max: hi=%h lo=%h dz=%b want fffffffe 00000001 0", hi, lo, dz);
    end
    n_checks++;
    if (lat !== 33) begin n_fail++; $display("FAIL latency: got %0d want 33", lat); end
    n_checks++;
    if (bc !== 33) begin n_fail++; $display("FAIL busy_cycles: got %0d want 33", bc); end
    @(negedge Clock);
    n_checks++;
    if (Done !== 1'b0 || Busy !== 1'b0) begin
      n_fail++; $display("FAIL done_pulse: done=%b busy=%b want 0 0", Done, Busy);
    end
  endtask

  task automatic test_mult_signed();
    logic [31:0] hi, lo; logic dz; int lat, bc; bit ec;
    run_op(2'd0, 32'hFFFF_FFFD, 32'd7, 0, hi, lo, dz, lat, bc, ec);
    n_checks++;
    if ({hi, lo} !== {32'hFFFF_FFFF, 32'hFFFF_FFEB}) begin
      n_fail++; $display("FAIL mult_neg3x7: hi=%h lo=%h want ffffffff ffffffeb", hi, lo);
    end
    @(negedge Clock);
    run_op(2'd0, 32'h8000_0000, 32'h8000_0000, 0, hi, lo, dz, lat, bc, ec);
    n_checks++;
    if ({hi, lo} !== {32'h4000_0000, 32'h0}) begin
      n_fail++; $display("FAIL mult_minxmin: hi=%h lo=%h want 40000000 00000000", hi, lo);
    end
    @(negedge Clock);
  endtask

  task automatic test_div();
    logic [31:0] hi, lo; logic dz; int lat, bc; bit ec;
    run_op(2'd2, 32'hFFFF_FFF9, 32'd2, 0, hi, lo, dz, lat, bc, ec);
    n_checks++;
    if ({hi, lo} !== {32'hFFFF_FFFF, 32'hFFFF_FFFD}) begin
      n_fail++; $display("FAIL div_neg7by2: hi=%h lo=%h want ffffffff fffffffd", hi, lo);
    end
    @(negedge Clock);
    run_op(2'd3, 32'd100, 32'd7, 0, hi, lo, dz, lat, bc, ec);
    n_checks++;
    if ({hi, lo} !== {32'd2, 32'd14}) begin
      n_fail++; $display("FAIL divu_100by7: hi=%h lo=%h want 2 e", hi, lo);
    end
    @(negedge Clock);
    run_op(2'd2, 32'h8000_0000, 32'hFFFF_FFFF, 0, hi, lo, dz, lat, bc, ec);
    n_checks++;
    if ({hi, lo, dz} !== {32'h0, 32'h8000_0000, 1'b0}) begin
      n_fail++; $display("FAIL div_overflow: hi=%h lo=%h dz=%b want 0 80000000 0", hi, lo, dz);
    end
    @(negedge Clock);
  endtask

  task automatic test_div_by_zero();
    logic [31:0] hi, lo; logic dz; int lat, bc; bit ec;
    run_op(2'd3, 32'd5, 32'd0, 0, hi, lo, dz, lat, bc, ec);
    n_checks++;
    if ({hi, lo, dz} !== {32'd5, 32'hFFFF_FFFF, 1'b1} || lat !== 33) begin
      n_fail++; $display("FAIL divu_by_zero: hi=%h lo=%h dz=%b lat=%0d want 5 ffffffff 1 33", hi, lo, dz, lat);
    end
    @(negedge Clock);
    n_checks++;
    if (Div_By_Zero !== 1'b0 || Done !== 1'b0) begin
      n_fail++; $display("FAIL dz_pulse: dz=%b done=%b want 0 0", Div_By_Zero, Done);
    end
  endtask

  task automatic test_busy_ignore();
    logic [31:0] hi, lo, a, b; logic dz; int lat, bc; bit ec; logic [64:0] exp;
    a = $urandom; b = $urandom;
    exp = model(2'd1, a, b);
    run_op(2'd1, a, b, 1, hi, lo, dz, lat, bc, ec);
    n_checks++;
    if ({hi, lo} !== exp[63:0] || lat !== 33) begin
      n_fail++; $display("FAIL busy_ignore: hi=%h lo=%h lat=%0d want %h %h 33", hi, lo, lat, exp[63:32], exp[31:0]);
    end
    n_checks++;
    if (ec !== 1'b0) begin n_fail++; $display("FAIL hilo_hold_while_busy: changed=%b want 0", ec); end
    @(negedge Clock);
    Write_Lo = 1'b1; Write_Data = 32'h1234_5678;
    @(negedge Clock);
    Write_Lo = 1'b0;
    n_checks++;
    if (Lo !== 32'h1234_5678 || Hi !== exp[63:32]) begin
      n_fail++; $display("FAIL mtlo: hi=%h lo=%h want %h 12345678", Hi, Lo, exp[63:32]);
    end
  endtask

  task automatic test_reset_mid_op();
    logic [31:0] hi, lo; logic dz; int lat, bc, dones; bit ec;
    Start = 1'b1; Op = 2'd3; Operand_A = 32'd100; Operand_B = 32'd7;
    @(negedge Clock);
    Start = 1'b0;
    repeat (9) @(negedge Clock);
    Reset = 1'b1;
    @(negedge Clock);
    Reset = 1'b0;
    n_checks++;
    if ({Hi, Lo, Busy, Done} !== '0) begin
      n_fail++; $display("FAIL reset_abort: hi=%h lo=%h busy=%b done=%b want 0", Hi, Lo, Busy, Done);
    end
    dones = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge Clock);
      if (Done) dones++;
    end
    n_checks++;
    if (dones !== 0) begin n_fail++; $display("FAIL no_done_after_abort: got %0d pulses want 0", dones); end
    run_op(2'd1, 32'd6, 32'd7, 0, hi, lo, dz, lat, bc, ec);
    n_checks++;
    if ({hi, lo} !== {32'd0, 32'd42} || lat !== 33) begin
      n_fail++; $display("FAIL multu_after_abort: hi=%h lo=%h lat=%0d want 0 2a 33", hi, lo, lat);
    end
    @(negedge Clock);
  endtask

  task automatic test_back_to_back();
    logic [31:0] hi, lo, a1, b1, a2, b2; logic dz; int lat, bc; bit ec; logic [64:0] e1, e2;
    a1 = $urandom; b1 = $urandom; a2 = $urandom; b2 = $urandom_range(1, 1000);
    e1 = model(2'd0, a1, b1);
    e2 = model(2'd2, a2, b2);
    run_op(2'd0, a1, b1, 0, hi, lo, dz, lat, bc, ec);
    n_checks++;
    if ({dz, hi, lo} !== e1 || lat !== 33) begin
      n_fail++; $display("FAIL b2b_first: hi=%h lo=%h lat=%0d want %h %h 33", hi, lo, lat, e1[63:32], e1[31:0]);
    end
    run_op(2'd2, a2, b2, 0, hi, lo, dz, lat, bc, ec);
    n_checks++;
    if ({dz, hi, lo} !== e2 || lat !== 33 || bc !== 33) begin
      n_fail++;
      $display("FAIL b2b_second: hi=%h lo=%h lat=%0d busy=%0d want %h %h 33 33", hi, lo, lat, bc, e2[63:32], e2[31:0]);
    end
    @(negedge Clock);
  endtask

  task automatic test_random();
    logic [31:0] hi, lo, a, b; logic dz; int lat, bc; bit ec; logic [1:0] op; logic [64:0] exp;
    for (int i = 0; i < 24; i++) begin
      op = 2'($urandom);
      a  = $urandom;
      b  = $urandom;
      case ($urandom_range(0, 5))
        0: b = '0;
        1: b = 32'hFFFF_FFFF;
        2: b = $urandom_range(1, 17);
        3: a = 32'h8000_0000;
        default: ;
      endcase
      exp = model(op, a, b);
      run_op(op, a, b, 0, hi, lo, dz, lat, bc, ec);
      n_checks++;
      if ({dz, hi, lo} !== exp || lat !== 33) begin
        n_fail++;
        $display("FAIL random_%0d op=%0d a=%h b=%h: hi=%h lo=%h dz=%b lat=%0d want %h %h %b 33",
                 i, op, a, b, hi, lo, dz, lat, exp[63:32], exp[31:0], exp[64]);
      end
      @(negedge Clock);
    end
  endtask

  initial begin
    test_reset();
    test_mult_unsigned();
    test_mult_signed();
    test_div();
    test_div_by_zero();
    test_busy_ignore();
    test_reset_mid_op();
    test_back_to_back();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
